regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter WIDTH, default 32, data bits per register.
REQ-002 Parameter DEPTH, default 32, number of registers; power of two, at least 4; AW = clog2(DEPTH).
REQ-003 Parameter NREAD, default 2, number of combinational read ports, 1..4.
REQ-004 Parameter ZERO_REG, default 1; when 1, register 0 always reads 0.
REQ-005 Port clk  in  1  clock; all state updates on rising edge.
REQ-006 Port reset  in  1  synchronous, active-low reset (reset==0 resets).
REQ-007 Port we  in  1  write enable.
REQ-008 Port wa  in  AW  write address.
REQ-009 Port wd  in  WIDTH  write data.
REQ-010 Port ra  in  NREAD*AW  packed read addresses; port i at bits [i*AW +: AW].
REQ-011 Port rd  out  NREAD*WIDTH  packed read data; port i at bits [i*WIDTH +: WIDTH].
REQ-012 Port clr_req  in  1  single-cycle request to clear all registers.
REQ-013 Port busy  out  1  high while a clear sweep is in progress.
REQ-014 Port wr_drop  out  1  registered one-cycle pulse flagging a write discarded because busy was high.

Function
REQ-015 The FSM SHALL have two states: IDLE and CLEAR, plus a sweep counter cnt of AW bits.
REQ-016 In CLEAR, each rising edge SHALL write 0 to entry cnt and increment cnt; when cnt==DEPTH-1 the FSM SHALL go to IDLE, with cnt wrapping to 0.
REQ-017 In IDLE, clr_req==1 SHALL move the FSM to CLEAR with cnt=0 on the next edge; clr_req in CLEAR SHALL be ignored and SHALL NOT restart the sweep.
REQ-018 busy SHALL equal (state==CLEAR), driven from a register; a sweep holds busy high for exactly DEPTH cycles.
REQ-019 In IDLE with we==1, wd SHALL be written to entry wa on the edge; a write to register 0 when ZERO_REG==1 SHALL be discarded without wr_drop.
REQ-020 A write with we==1 while busy==1 SHALL be discarded and wr_drop SHALL be 1 in the following cycle only.
REQ-021 A write and clr_req asserted in the same IDLE cycle: the write SHALL complete and the sweep SHALL start on the same edge; the written entry is cleared later by the sweep.
REQ-022 Reads SHALL be combinational with zero latency; while busy==1 every rd port SHALL return 0.
REQ-023 With ZERO_REG==1, ra==0 SHALL return 0 on that port regardless of bypass or write activity.
REQ-024 Multiple read ports SHALL NOT interfere with each other; identical addresses SHALL return identical data.

Reset
REQ-025 On any edge with reset==0: state=CLEAR, cnt=0, wr_drop=0, busy=1, and no array entry is written on that edge.
REQ-026 After reset returns to 1, the sweep SHALL run DEPTH cycles and busy SHALL fall on the DEPTH-th edge.
REQ-027 Reset asserted mid-sweep SHALL restart the sweep from cnt=0.
REQ-028 The storage array SHALL NOT be reset by reset except via the sweep.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN: when defined, a read port with ra==wa, we==1 and busy==0 (and not register 0 when ZERO_REG==1) SHALL return wd in the same cycle (write-through). When undefined, it SHALL return the old stored value until after the edge.

Structure
REQ-030 Package regfile_pkg SHALL hold the FSM state typedef (IDLE, CLEAR) and the NREAD maximum constant (4).
REQ-031 Sub-module regfile_clr_fsm SHALL contain the state register, cnt, busy and wr_drop; the array and read and bypass muxing stay in regfile_mp.

Verification (WIDTH=32, DEPTH=32, NREAD=2, ZERO_REG=1)
REQ-032 Hold reset low for 3 cycles, then release -> busy=1 for exactly 32 cycles; all 32 entries then read 0x00000000.
REQ-033 Write 0xDEADBEEF to reg 5, next cycle read ra0=5, ra1=0 -> rd0=0xDEADBEEF, rd1=0; write 0x1 to reg 0, then read reg 0 -> 0.
REQ-034 Same-cycle we=1, wa=7, wd=0x12345678 with ra0=7 -> rd0=0x12345678 with REGFILE_BYPASS_EN defined; otherwise the prior value, with 0x12345678 returned after the edge.
REQ-035 Pulse clr_req, then on sweep cycle 10 assert we=1, wa=3, wd=0xAA -> write discarded, wr_drop=1 for one cycle, reg 3 reads 0 after the sweep; a second clr_req mid-sweep leaves busy duration at 32 cycles.
REQ-036 Assert reset at sweep cycle 20 for one cycle -> cnt restarts and busy stays high for 32 cycles after reset release.
REQ-037 Assert we=1, wa=9, wd=0x55 and clr_req together in IDLE -> busy rises on the next edge and reg 9 reads 0 after the sweep.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and limits for the multi-port register file with clear sweep.
package regfile_pkg;

    localparam int unsigned NREAD_MAX = 4;
    localparam int unsigned DEPTH_MIN = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // True when the parameter set is one the array and sweep logic support.
    function automatic bit cfg_ok(input int unsigned depth, input int unsigned nread);
        return (depth >= DEPTH_MIN) && ((depth & (depth - 1)) == 0) &&
               (nread >= 1) && (nread <= NREAD_MAX);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write/read/clear bus for regfile_mp; master drives requests, slave returns data and status.
interface regfile_mp_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned NREAD = 2
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic                   we;
    logic [AW-1:0]          wa;
    logic [WIDTH-1:0]       wd;
    logic [NREAD*AW-1:0]    ra;
    logic [NREAD*WIDTH-1:0] rd;
    logic                   clr_req;
    logic                   busy;
    logic                   wr_drop;

    modport master (
        output we, wa, wd, ra, clr_req,
        input  rd, busy, wr_drop
    );

    modport slave (
        input  we, wa, wd, ra, clr_req,
        output rd, busy, wr_drop
    );

endinterface

// File: rtl/regfile_clr_fsm.sv
// Clear-sweep controller: IDLE/CLEAR state, sweep address, busy and dropped-write flag.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter  int unsigned DEPTH = 32,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    input  logic          we,
    output logic          busy,
    output logic          wr_drop,
    output logic [AW-1:0] cnt
);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          drop_q, drop_d;

    // Reset lands in CLEAR so the array is swept before first use.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                drop_d = we;
                cnt_d  = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
        endcase
        busy_d = (state_d == CLEAR);
    end

    assign busy    = busy_q;
    assign wr_drop = drop_q;
    assign cnt     = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a hardware clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int unsigned WIDTH    = 32,
    parameter  int unsigned DEPTH    = 32,
    parameter  int unsigned NREAD    = 2,
    parameter  int unsigned ZERO_REG = 1,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input logic         clk,
    input logic         reset,
    regfile_mp_if.slave bus
);

    localparam bit CFG_OK = cfg_ok(DEPTH, NREAD);
    localparam bit ZR     = (ZERO_REG != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             busy;
    logic             wr_drop;
    logic [AW-1:0]    cnt;
    logic             wa_is_zero_c;

    regfile_clr_fsm #(
        .DEPTH (DEPTH)
    ) u_clr_fsm (
        .clk     (clk),
        .reset   (reset),
        .clr_req (bus.clr_req),
        .we      (bus.we),
        .busy    (busy),
        .wr_drop (wr_drop),
        .cnt     (cnt)
    );

    assign bus.busy     = busy;
    assign bus.wr_drop  = wr_drop;
    assign wa_is_zero_c = ZR && (bus.wa == '0);

    // Sweep has priority; user writes only land while idle. Not touched on a reset edge.
    always_ff @(posedge clk) begin
        if (reset && CFG_OK) begin
            if (busy) begin
                mem[cnt] <= '0;
            end else if (bus.we && !wa_is_zero_c) begin
                mem[bus.wa] <= bus.wd;
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;

        assign addr = bus.ra[i*AW +: AW];

        always_comb begin
            data = mem[addr];
            if (busy || (ZR && (addr == '0))) begin
                data = '0;
            end
`ifdef REGFILE_BYPASS_EN
            else if (bus.we && (addr == bus.wa)) begin
                data = bus.wd;
            end
`endif
        end

        assign bus.rd[i*WIDTH +: WIDTH] = data;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (WIDTH=32, DEPTH=32, NREAD=2, ZERO_REG=1).
module tb_regfile_mp;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    regfile_mp_if #(.WIDTH(32), .DEPTH(32), .NREAD(2)) bus ();

    regfile_mp #(
        .WIDTH    (32),
        .DEPTH    (32),
        .NREAD    (2),
        .ZERO_REG (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vt [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
        bus.ra = {a1, a0};
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int          n;
    int          m;
    logic [31:0] exp_bp;

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b0;
        bus.we      = 1'b0;
        bus.wa      = '0;
        bus.wd      = '0;
        bus.ra      = '0;
        bus.clr_req = 1'b0;

        //         we    wa     wd            ra0    ra1    e0            e1
        vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd2,  32'h0,        32'h0};
        vt[1] = '{1'b1, 5'd0,  32'h00000001, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vt[2] = '{1'b1, 5'd10, 32'hCAFEF00D, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        vt[3] = '{1'b0, 5'd10, 32'hFFFFFFFF, 5'd10, 5'd10, 32'hCAFEF00D, 32'hCAFEF00D};
        vt[4] = '{1'b1, 5'd31, 32'h80000001, 5'd10, 5'd5,  32'hCAFEF00D, 32'hDEADBEEF};
        vt[5] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd0,  32'h80000001, 32'h0};
        vt[6] = '{1'b1, 5'd5,  32'h11111111, 5'd31, 5'd10, 32'h80000001, 32'hCAFEF00D};
        vt[7] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'h11111111, 32'h11111111};

        // Reset held for three edges, then the power-on sweep
        repeat (3) step();
        chk("rst_busy", 32'(bus.busy), 32'd1);
        chk("rst_wr_drop", 32'(bus.wr_drop), 32'd0);
        set_ra(5'd5, 5'd0);
        #4;
        chk("rst_rd0_blank", bus.rd[31:0], 32'h0);
        reset = 1'b1;
        wait_idle(n);
        chk("por_busy_len", 32'(n), 32'd32);
        for (int i = 0; i < 32; i++) begin
            step();
            set_ra(5'(i), 5'(31 - i));
            #4;
            chk($sformatf("por_clear_rd0[%0d]", i), bus.rd[31:0], 32'h0);
            chk($sformatf("por_clear_rd1[%0d]", i), bus.rd[63:32], 32'h0);
        end

        // Table: write one entry per cycle while reading others
        for (int i = 0; i < 8; i++) begin
            step();
            bus.we = vt[i].we;
            bus.wa = vt[i].wa;
            bus.wd = vt[i].wd;
            set_ra(vt[i].ra0, vt[i].ra1);
            #4;
            chk($sformatf("vec%0d_rd0", i), bus.rd[31:0], vt[i].e0);
            chk($sformatf("vec%0d_rd1", i), bus.rd[63:32], vt[i].e1);
            chk($sformatf("vec%0d_wr_drop", i), 32'(bus.wr_drop), 32'd0);
        end
        bus.we = 1'b0;

        // Same-cycle write and read of reg 7
        step();
        bus.we = 1'b1;
        bus.wa = 5'd7;
        bus.wd = 32'h12345678;
        set_ra(5'd7, 5'd0);
`ifdef REGFILE_BYPASS_EN
        exp_bp = 32'h12345678;
`else
        exp_bp = 32'h0;
`endif
        #4;
        chk("wt_same_cycle_rd0", bus.rd[31:0], exp_bp);
        chk("wt_same_cycle_rd1", bus.rd[63:32], 32'h0);
        step();
        bus.we = 1'b0;
        #4;
        chk("wt_after_edge_rd0", bus.rd[31:0], 32'h12345678);

        // Sweep with a dropped write and an ignored second clr_req
        step();
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        chk("clr_busy_rise", 32'(bus.busy), 32'd1);
        set_ra(5'd5, 5'd7);
        #4;
        chk("clr_rd0_blank", bus.rd[31:0], 32'h0);
        chk("clr_rd1_blank", bus.rd[63:32], 32'h0);
        repeat (9) step();
        bus.we = 1'b1;
        bus.wa = 5'd3;
        bus.wd = 32'h000000AA;
        step();
        bus.we = 1'b0;
        chk("drop_pulse", 32'(bus.wr_drop), 32'd1);
        step();
        chk("drop_one_cycle", 32'(bus.wr_drop), 32'd0);
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        wait_idle(m);
        chk("clr_busy_len", 32'(12 + m), 32'd32);
        set_ra(5'd3, 5'd5);
        #4;
        chk("clr_reg3", bus.rd[31:0], 32'h0);
        chk("clr_reg5", bus.rd[63:32], 32'h0);

        // Reset at sweep cycle 20 restarts the count
        step();
        bus.we = 1'b1;
        bus.wa = 5'd12;
        bus.wd = 32'h00000077;
        step();
        bus.we = 1'b0;
        set_ra(5'd12, 5'd0);
        #4;
        chk("pre_rst_reg12", bus.rd[31:0], 32'h00000077);
        step();
        bus.clr_req = 1'b1;
        step();
        bus.clr_req = 1'b0;
        repeat (20) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd1);
        chk("mid_rst_wr_drop", 32'(bus.wr_drop), 32'd0);
        wait_idle(m);
        chk("mid_rst_busy_len", 32'(m), 32'd32);
        #4;
        chk("mid_rst_reg12", bus.rd[31:0], 32'h0);

        // Write and clr_req in the same idle cycle
        step();
        bus.we      = 1'b1;
        bus.wa      = 5'd9;
        bus.wd      = 32'h00000055;
        bus.clr_req = 1'b1;
        set_ra(5'd9, 5'd9);
`ifdef REGFILE_BYPASS_EN
        exp_bp = 32'h00000055;
`else
        exp_bp = 32'h0;
`endif
        #4;
        chk("wc_same_cycle_rd0", bus.rd[31:0], exp_bp);
        step();
        bus.we      = 1'b0;
        bus.clr_req = 1'b0;
        chk("wc_busy_rise", 32'(bus.busy), 32'd1);
        chk("wc_no_drop", 32'(bus.wr_drop), 32'd0);
        wait_idle(m);
        chk("wc_busy_len", 32'(m), 32'd32);
        #4;
        chk("wc_reg9_rd0", bus.rd[31:0], 32'h0);
        chk("wc_reg9_rd1", bus.rd[63:32], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
